cache_mem_arbiter: RTL and testbench

Shares the single external memory port between the data cache's two line-level requesters: miss refill (read) and dirty-victim writeback (write).
- Grants one requester at a time and sequences a fixed-length word burst per cache line.
- Returns per-beat read data and completion or error pulses.
- Sits between the cache controller FSM (its MISSREPAIR and WRITEBACK states) and the memory interface.

---
 rtl/cache_mem_pkg.sv | 19 +
 rtl/burst_counter.sv | 51 +++++
 rtl/cache_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_pkg.sv
// Shared types and line geometry for the cache memory-port arbiter.
// State and grant encodings are plain typed constants so legacy tools can read them.
package cache_mem_pkg;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE     = 2'd0;
  localparam arb_state_t RD_BURST = 2'd1;
  localparam arb_state_t WR_BURST = 2'd2;
  localparam arb_state_t RESP     = 2'd3;

  typedef logic grant_t;
  localparam grant_t READ  = 1'b0;
  localparam grant_t WRITE = 1'b1;

  localparam int LINE_BYTES = 16;
  localparam int WORD_BYTES = 4;
  localparam int BEATS      = LINE_BYTES / WORD_BYTES;

endpackage

// File: rtl/burst_counter.sv
// Beat counter and no-ack watchdog for one line burst.
// Both clear on grant; an ack advances the beat and rearms the watchdog.
module burst_counter #(
  parameter int  BEATS   = 4,
  parameter int  TIMEOUT = 255,
  localparam int BEAT_W  = $clog2(BEATS),
  localparam int WD_W    = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              ack,
  input  logic              tick,
  output logic [BEAT_W-1:0] beat,
  output logic              last,
  output logic              timeout
);

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  assign beat    = beat_q;
  assign last    = (beat_q == BEAT_W'(BEATS - 1));
  assign timeout = (wd_q == WD_W'(TIMEOUT));

  // The last beat holds rather than wrapping; the next grant clears it.
  always_comb begin
    beat_d = beat_q;
    wd_d   = wd_q;
    if (clear) begin
      beat_d = '0;
      wd_d   = '0;
    end else if (ack) begin
      wd_d = '0;
      if (!last) beat_d = beat_q + 1'b1;
    end else if (tick && !timeout) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q <= '0;
      wd_q   <= '0;
    end else begin
      beat_q <= beat_d;
      wd_q   <= wd_d;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between line refill (read) and victim writeback (write),
// sequencing a fixed word burst per line with a no-ack watchdog.
//   state    | meaning
//   IDLE     | arbitrate; latch line of the winner
//   RD_BURST | refill beats on the bus, rdata passed through on ack
//   WR_BURST | writeback beats on the bus, wr_data driven on ack
//   RESP     | one-cycle done pulse for the burst just finished
module cache_mem_arbiter
  import cache_mem_pkg::*;
#(
  parameter int  ADDR_W   = 32,
  parameter int  DATA_W   = 32,
  parameter int  OFFSET_W = 4,
  parameter int  TIMEOUT  = 255,
  localparam int NBEATS   = (2 ** OFFSET_W) / (DATA_W / 8),
  localparam int BEAT_W   = $clog2(NBEATS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_rq,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [BEAT_W-1:0] rd_beat,
  output logic              rd_done,
  output logic              rd_err,
  input  logic              wr_rq,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [BEAT_W-1:0] wr_beat,
  output logic              wr_done,
  output logic              wr_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LINE_W = ADDR_W - OFFSET_W;
  localparam int BYTE_W = OFFSET_W - BEAT_W;

  arb_state_t        state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [LINE_W-1:0] rd_line, wr_line;
  logic [BEAT_W-1:0] beat;
  logic              in_burst, cnt_clear, beat_last, wd_timeout, expire;
  logic              unused_addr_bits;

  assign rd_line = rd_addr[ADDR_W-1:OFFSET_W];
  assign wr_line = wr_addr[ADDR_W-1:OFFSET_W];
  assign unused_addr_bits = ^{rd_addr[OFFSET_W-1:0], wr_addr[OFFSET_W-1:0]};

  assign in_burst = (state_q == RD_BURST) || (state_q == WR_BURST);
  assign expire   = in_burst && !mem_ack && wd_timeout;

  burst_counter #(.BEATS(NBEATS), .TIMEOUT(TIMEOUT)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .ack     (in_burst && mem_ack),
    .tick    (in_burst && !mem_ack),
    .beat    (beat),
    .last    (beat_last),
    .timeout (wd_timeout)
  );

  // Same-line tie goes to the writeback so a refill never reads stale memory.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    line_d       = line_q;
    cnt_clear    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_rq || wr_rq) begin
          cnt_clear = 1'b1;
          if (rd_rq && wr_rq)
            last_grant_d = (rd_line == wr_line) ? WRITE
                         : ((last_grant_q == WRITE) ? READ : WRITE);
          else
            last_grant_d = wr_rq ? WRITE : READ;
          line_d  = (last_grant_d == WRITE) ? wr_line : rd_line;
          state_d = (last_grant_d == WRITE) ? WR_BURST : RD_BURST;
        end
      end
      RD_BURST, WR_BURST: begin
        if (mem_ack && beat_last) state_d = RESP;
        else if (expire)          state_d = IDLE;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= WRITE;
      line_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      line_q       <= line_d;
    end
  end

  // last_grant_q still names the finished burst while in RESP.
  assign mem_req   = in_burst;
  assign mem_we    = (state_q == WR_BURST);
  assign mem_addr  = in_burst ? {line_q, beat, {BYTE_W{1'b0}}} : '0;
  assign mem_wdata = mem_we ? wr_data : '0;

  assign rd_valid = (state_q == RD_BURST) && mem_ack;
  assign rd_data  = rd_valid ? mem_rdata : '0;
  assign rd_beat  = (state_q == RD_BURST) ? beat : '0;
  assign rd_done  = (state_q == RESP) && (last_grant_q == READ);
  assign rd_err   = (state_q == RD_BURST) && expire;

  assign wr_beat  = (state_q == WR_BURST) ? beat : '0;
  assign wr_done  = (state_q == RESP) && (last_grant_q == WRITE);
  assign wr_err   = (state_q == WR_BURST) && expire;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scenario bench for cache_mem_arbiter: expected bus beats are queued when a request
// is driven and popped as the DUT acknowledges them on the memory port.
module tb_cache_mem_arbiter;

  localparam logic [31:0] RD_KEY = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_rq, wr_rq;
  logic [31:0] rd_addr, wr_addr, wr_data, rd_data, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  rd_beat, wr_beat;
  logic        rd_valid, rd_done, rd_err, wr_done, wr_err;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] wdata_base;
  int          ack_mode;
  int          ack_cnt;
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  beat;
  } exp_t;
  exp_t exp_q[$];

  cache_mem_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .rd_rq(rd_rq), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_beat(rd_beat), .rd_done(rd_done), .rd_err(rd_err),
    .wr_rq(wr_rq), .wr_addr(wr_addr), .wr_data(wr_data), .wr_beat(wr_beat),
    .wr_done(wr_done), .wr_err(wr_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Simple memory and writeback-source models.
  assign mem_rdata = mem_addr ^ RD_KEY;
  assign wr_data   = wdata_base + {30'b0, wr_beat};

  initial begin
    ack_cnt = 0;
    mem_ack = 1'b0;
  end

  // 0 = never ack, 1 = ack every cycle, 2 = ack every third cycle
  always @(posedge clk) begin
    #1;
    ack_cnt = ack_cnt + 1;
    case (ack_mode)
      0:       mem_ack = 1'b0;
      1:       mem_ack = 1'b1;
      default: mem_ack = (ack_cnt % 3 == 0);
    endcase
  end

  // Scoreboard: every accepted beat must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && mem_req && mem_ack) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected_beat: got we=%0b addr=%h, required no beat", mem_we, mem_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (mem_we !== e.we || mem_addr !== e.addr || mem_wdata !== e.wdata) begin
          n_bad++;
          $display("FAIL sb_bus: got we=%0b addr=%h wdata=%h, required we=%0b addr=%h wdata=%h",
                   mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
        end
        n_cmp++;
        if (!e.we) begin
          if (rd_valid !== 1'b1 || rd_data !== e.rdata || rd_beat !== e.beat) begin
            n_bad++;
            $display("FAIL sb_read: got valid=%0b data=%h beat=%0d, required valid=1 data=%h beat=%0d",
                     rd_valid, rd_data, rd_beat, e.rdata, e.beat);
          end
        end else begin
          if (rd_valid !== 1'b0 || wr_beat !== e.beat) begin
            n_bad++;
            $display("FAIL sb_write: got rd_valid=%0b wr_beat=%0d, required rd_valid=0 wr_beat=%0d",
                     rd_valid, wr_beat, e.beat);
          end
        end
      end
    end
  end

  task automatic push_line(input logic we, input logic [31:0] line_addr, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.we    = we;
      e.addr  = (line_addr & 32'hFFFF_FFF0) + 32'(i * 4);
      e.wdata = we ? wdata_base + 32'(i) : 32'h0;
      e.rdata = we ? 32'h0 : (e.addr ^ RD_KEY);
      e.beat  = 2'(i);
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rd_rq = 1'b0; wr_rq = 1'b0;
    rd_addr = '0; wr_addr = '0; wdata_base = '0; ack_mode = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({rd_valid, rd_data, rd_beat, rd_done, rd_err, wr_beat, wr_done, wr_err,
         mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got req=%0b we=%0b addr=%h rd_valid=%0b dones=%0b%0b errs=%0b%0b, required all 0",
               mem_req, mem_we, mem_addr, rd_valid, rd_done, wr_done, rd_err, wr_err);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_read();
    int nvalid = 0;
    int last_ack = -1;
    int done_c = -1;
    bit err_seen = 0;
    ack_mode = 1;
    push_line(1'b0, 32'h0000_1230, 4);
    @(posedge clk); #1;
    rd_rq = 1'b1; rd_addr = 32'h0000_1234;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_cmp++;
        if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rd_latency0: got mem_req=%0b, required 0", mem_req); end
      end
      if (c == 1) begin
        n_cmp++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0) begin
          n_bad++; $display("FAIL rd_latency1: got mem_req=%0b mem_we=%0b, required 1/0", mem_req, mem_we);
        end
      end
      if (rd_valid) begin nvalid++; last_ack = c; end
      if (rd_err || wr_err) err_seen = 1;
      if (rd_done) begin done_c = c; break; end
    end
    @(posedge clk); #1;
    rd_rq = 1'b0;
    n_cmp++;
    if (nvalid != 4) begin n_bad++; $display("FAIL rd_valid_count: got %0d, required 4", nvalid); end
    n_cmp++;
    if (done_c < 0 || done_c != last_ack + 1) begin
      n_bad++; $display("FAIL rd_done_timing: got done at %0d, required %0d", done_c, last_ack + 1);
    end
    n_cmp++;
    if (err_seen) begin n_bad++; $display("FAIL rd_no_err: got err pulse, required none"); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL rd_beats_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_write_stall();
    int acks = 0;
    int last_ack = -1;
    int done_c = -1;
    bit err_seen = 0;
    bit we_low = 0;
    ack_mode = 2;
    wdata_base = 32'h5700_0000;
    push_line(1'b1, 32'h0000_ABC0, 4);
    @(posedge clk); #1;
    wr_rq = 1'b1; wr_addr = 32'h0000_ABC0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (mem_req && !mem_we) we_low = 1;
      if (mem_req && mem_ack) begin acks++; last_ack = c; end
      if (rd_err || wr_err) err_seen = 1;
      if (wr_done) begin done_c = c; break; end
    end
    @(posedge clk); #1;
    wr_rq = 1'b0;
    n_cmp++;
    if (acks != 4) begin n_bad++; $display("FAIL wr_ack_count: got %0d, required 4", acks); end
    n_cmp++;
    if (done_c < 0 || done_c != last_ack + 1) begin
      n_bad++; $display("FAIL wr_done_timing: got done at %0d, required %0d", done_c, last_ack + 1);
    end
    n_cmp++;
    if (err_seen || we_low) begin
      n_bad++; $display("FAIL wr_clean: got err=%0b we_low=%0b, required 0/0", err_seen, we_low);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL wr_beats_left: got %0d, required 0", exp_q.size()); end
  endtask

  // Both requesters stay high: grants must alternate read, write, read.
  task automatic test_tie_round_robin();
    int order[3];
    int ndone = 0;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    ack_mode = 1;
    wdata_base = 32'h2200_0000;
    push_line(1'b0, 32'h0000_0100, 4);
    push_line(1'b1, 32'h0000_0200, 4);
    push_line(1'b0, 32'h0000_0100, 4);
    rd_rq = 1'b1; rd_addr = 32'h0000_0100;
    wr_rq = 1'b1; wr_addr = 32'h0000_0200;
    for (int c = 0; c < 100 && ndone < 3; c++) begin
      @(negedge clk);
      if (rd_done) begin order[ndone] = 0; ndone++; end
      else if (wr_done) begin order[ndone] = 1; ndone++; end
    end
    @(posedge clk); #1;
    rd_rq = 1'b0; wr_rq = 1'b0;
    n_cmp++;
    if (ndone != 3) begin n_bad++; $display("FAIL rr_done_count: got %0d, required 3", ndone); end
    else begin
      n_cmp++;
      if (order[0] != 0 || order[1] != 1 || order[2] != 0) begin
        n_bad++; $display("FAIL rr_order: got %0d%0d%0d, required 010 (0=read)", order[0], order[1], order[2]);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL rr_beats_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_tie_same_line();
    int first = -1;
    int ndone = 0;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    ack_mode = 1;
    wdata_base = 32'h4400_0000;
    push_line(1'b1, 32'h0000_0040, 4);
    push_line(1'b0, 32'h0000_0040, 4);
    rd_rq = 1'b1; rd_addr = 32'h0000_0040;
    wr_rq = 1'b1; wr_addr = 32'h0000_004C;
    for (int c = 0; c < 60 && ndone < 2; c++) begin
      @(negedge clk);
      if (wr_done) begin
        if (first < 0) first = 1;
        ndone++;
        @(posedge clk); #1; wr_rq = 1'b0;
      end else if (rd_done) begin
        if (first < 0) first = 0;
        ndone++;
        @(posedge clk); #1; rd_rq = 1'b0;
      end
    end
    rd_rq = 1'b0; wr_rq = 1'b0;
    n_cmp++;
    if (first != 1 || ndone != 2) begin
      n_bad++; $display("FAIL hazard_write_first: got first=%0d dones=%0d, required first=1 dones=2", first, ndone);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL hazard_beats_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    int err_c = -1;
    int req_cycles = 0;
    bit done_seen = 0;
    bit stray_req = 0;
    ack_mode = 0;
    @(posedge clk); #1;
    rd_rq = 1'b1; rd_addr = 32'h0000_3000;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rd_done) done_seen = 1;
      if (rd_err) begin err_c = c; break; end
      if (mem_req) req_cycles++;
    end
    n_cmp++;
    if (err_c != 9 || req_cycles != 8) begin
      n_bad++; $display("FAIL timeout_point: got err at %0d after %0d stalls, required 9 after 8", err_c, req_cycles);
    end
    @(posedge clk); #1;
    rd_rq = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b0 || rd_err !== 1'b0) begin
      n_bad++; $display("FAIL timeout_drop: got mem_req=%0b rd_err=%0b, required 0/0", mem_req, rd_err);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rd_done) done_seen = 1;
      if (mem_req) stray_req = 1;
    end
    n_cmp++;
    if (done_seen || stray_req) begin
      n_bad++; $display("FAIL timeout_idle: got done=%0b req=%0b, required 0/0", done_seen, stray_req);
    end
  endtask

  task automatic test_reset_mid_burst();
    int wacks = 0;
    int rd_done_c = -1;
    bit wr_seen = 0;
    bit junk = 0;
    ack_mode = 1;
    wdata_base = 32'h3300_0000;
    push_line(1'b1, 32'h0000_7700, 2);
    @(posedge clk); #1;
    wr_rq = 1'b1; wr_addr = 32'h0000_7700;
    for (int c = 0; c < 20 && wacks < 2; c++) begin
      @(negedge clk);
      if (mem_req && mem_ack) wacks++;
    end
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0; wr_rq = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rd_valid, rd_data, rd_beat, rd_done, rd_err, wr_beat, wr_done, wr_err,
         mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got req=%0b we=%0b addr=%h wr_done=%0b, required all 0",
               mem_req, mem_we, mem_addr, wr_done);
    end
    n_cmp++;
    if (wacks != 2) begin n_bad++; $display("FAIL midreset_beats: got %0d, required 2", wacks); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (wr_done || wr_err || mem_req) junk = 1;
    end
    n_cmp++;
    if (junk) begin n_bad++; $display("FAIL midreset_silent: got done/err/req activity, required none"); end
    push_line(1'b0, 32'h0000_0500, 4);
    @(posedge clk); #1;
    rd_rq = 1'b1; rd_addr = 32'h0000_0500;
    wr_rq = 1'b1; wr_addr = 32'h0000_0600;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mem_req && mem_we) wr_seen = 1;
      if (rd_done) begin rd_done_c = c; break; end
    end
    @(posedge clk); #1;
    rd_rq = 1'b0; wr_rq = 1'b0;
    n_cmp++;
    if (rd_done_c < 0 || wr_seen) begin
      n_bad++; $display("FAIL midreset_read_wins: got rd_done_at=%0d wr_seen=%0b, required >=0/0", rd_done_c, wr_seen);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL midreset_beats_left: got %0d, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_stall();
    test_tie_round_robin();
    test_tie_same_line();
    test_timeout();
    test_reset_mid_burst();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not complete, required finish before 50000");
    $fatal(1, "global time limit");
  end

endmodule
